// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl -- exception / interrupt sequencer between the WB stage and CP0.
//
// Picks the highest-priority event for the instruction in WB: a pending
// interrupt, one of the per-instruction exception flags, or an eret. It then
// issues a one-cycle commit strobe to CP0 (wb_ex or eret_commit), flushes the
// pipeline and holds a redirect request to fetch until fetch accepts it.
// Only one event is in flight at a time: while the redirect is outstanding,
// the WB inputs are ignored.
//
// Handshake: redirect_valid/redirect_pc form a valid/ready source. Once
// redirect_valid is raised, it and redirect_pc stay stable until a cycle in
// which redirect_ready is also high. That cycle is the transfer. The block is
// back in IDLE on the following cycle. There is no timeout.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ws_valid, ws_pc,  WB instruction valid, PC, delay-slot flag
//   ws_bd
//   ws_ex_*           per-instruction exception flags
//   ws_data_addr      load/store effective address (BadVAddr source)
//   ws_eret           WB instruction is eret
//   cp0_status/cause  interrupt enable/mask/pending sources
//   cp0_epc           eret return target
//   wb_ex, wb_bd, wb_excode, wb_pc, wb_badvaddr   exception commit to CP0
//   eret_commit       eret commit strobe to CP0
//   flush             kill all pipeline stages
//   redirect_valid, redirect_pc, redirect_ready   redirect handshake to fetch
// -----------------------------------------------------------------------------
module exc_ctrl #(
    parameter logic [31:0] EX_ENTRY   = 32'hbfc00380,
    parameter logic [4:0]  INT_EXCODE = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic        ws_bd,
    input  logic        ws_ex_adel_if,
    input  logic        ws_ex_ri,
    input  logic        ws_ex_ov,
    input  logic        ws_ex_sys,
    input  logic        ws_ex_bp,
    input  logic        ws_ex_adel_ld,
    input  logic        ws_ex_ades,
    input  logic [31:0] ws_data_addr,
    input  logic        ws_eret,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        wb_ex,
    output logic        wb_bd,
    output logic [4:0]  wb_excode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_badvaddr,
    output logic        eret_commit,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        int_pend_r;
    logic        int_pend_d;
    logic        any_ex;
    logic        take;
    logic        eret_take;
    logic [4:0]  excode;
    logic [31:0] badvaddr;

    // Status/Cause bits that play no part in the interrupt decision.
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2],
                               cp0_cause[31:16], cp0_cause[7:0]};

    // Interrupt pending is sampled one cycle ahead of its use. A fresh
    // Status/Cause write therefore affects only the next WB instruction.
    assign int_pend_d = cp0_status[0] & ~cp0_status[1]
                      & (|(cp0_cause[15:8] & cp0_status[15:8]));

    assign any_ex = ws_ex_adel_if | ws_ex_ri | ws_ex_ov | ws_ex_sys
                  | ws_ex_bp | ws_ex_adel_ld | ws_ex_ades;

    // Gating with rst keeps every strobe low while reset is asserted.
    assign take      = ~rst & (state_q == S_IDLE) & ws_valid & (int_pend_r | any_ex);
    assign eret_take = ~rst & (state_q == S_IDLE) & ws_valid & ws_eret & ~take;

    // Priority encode: interrupt first, then fetch-side faults before
    // decode/execute faults, and memory-stage faults last.
    always_comb begin
        excode   = 5'd0;
        badvaddr = 32'd0;
        if (int_pend_r) begin
            excode = INT_EXCODE;
        end else if (ws_ex_adel_if) begin
            excode   = 5'd4;
            badvaddr = ws_pc;
        end else if (ws_ex_ri) begin
            excode = 5'd10;
        end else if (ws_ex_ov) begin
            excode = 5'd12;
        end else if (ws_ex_sys) begin
            excode = 5'd8;
        end else if (ws_ex_bp) begin
            excode = 5'd9;
        end else if (ws_ex_adel_ld) begin
            excode   = 5'd4;
            badvaddr = ws_data_addr;
        end else if (ws_ex_ades) begin
            excode   = 5'd5;
            badvaddr = ws_data_addr;
        end
    end

    // Next state and outputs.
    always_comb begin
        state_d        = state_q;
        wb_ex          = 1'b0;
        wb_bd          = 1'b0;
        wb_excode      = 5'd0;
        wb_pc          = 32'd0;
        wb_badvaddr    = 32'd0;
        eret_commit    = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    wb_ex       = 1'b1;
                    wb_bd       = ws_bd;
                    wb_excode   = excode;
                    wb_pc       = ws_pc;
                    wb_badvaddr = badvaddr;
                    flush       = 1'b1;
                    state_d     = S_REDIRECT;
                end else if (eret_take) begin
                    eret_commit = 1'b1;
                    flush       = 1'b1;
                    state_d     = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            int_pend_r  <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            state_q    <= state_d;
            int_pend_r <= int_pend_d;
            if (take) begin
                redirect_pc <= EX_ENTRY;
            end else if (eret_take) begin
                redirect_pc <= cp0_epc;
            end
        end
    end

endmodule
